// File: rtl/mem_pkg.sv
// Shared widths, typedefs and FSM state encoding for the memory responder.
package mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {CLEAR, SERVE} resp_state_e;
endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Storage has no reset; the responder's clear sequence defines it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_resp.sv
// Memory responder: post-reset self-clear, command decode, sticky error flag
// and saturating access counters around a mem_array instance.
//   state | meaning
//   CLEAR | pointer sweeps 0..DEPTH-1 writing zeros; commands rejected
//   SERVE | single read or write per cycle; terminal until rst
module mem_resp #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              proto_err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);
  import mem_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  resp_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              proto_err_q, proto_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    proto_err_d = proto_err_q;
    rd_valid_d  = 1'b0;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = data_in;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (&ptr_q) state_d = SERVE;
        if (read || write) proto_err_d = 1'b1;
      end
      SERVE: begin
        if (read && write) begin
          proto_err_d = 1'b1;
        end else if (write) begin
          mem_we = 1'b1;
          if (wr_count_q != CNT_MAX) wr_count_d = wr_count_q + 1'b1;
        end else if (read) begin
          mem_re     = 1'b1;
          rd_valid_d = 1'b1;
          if (rd_count_q != CNT_MAX) rd_count_d = rd_count_q + 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      proto_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      proto_err_q <= proto_err_d;
      rd_valid_q  <= rd_valid_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (addr),
    .rdata_o (data_out)
  );

  assign busy      = (state_q == CLEAR);
  assign proto_err = proto_err_q;
  assign rd_valid  = rd_valid_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: constant vector table, directed reset/clear
// sequences and randomized traffic against an array-based reference model.
module tb_mem_resp;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int CW    = 6;
  localparam int DEPTH = 32;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, busy, proto_err;
  logic [CW-1:0] wr_count, rd_count;

  mem_resp #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
    .busy(busy), .proto_err(proto_err), .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: edges since reset decide busy; array is all-zero after reset
  logic [DW-1:0] m_mem [DEPTH];
  int            m_edges;
  logic [DW-1:0] m_dout;
  bit            m_valid, m_perr;
  int            m_wr, m_rd;

  typedef struct {
    bit          r;
    bit          w;
    logic [4:0]  a;
    logic [7:0]  d;
    logic [7:0]  e_dout;
    bit          e_valid;
    bit          e_perr;
    int          e_wr;
    int          e_rd;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_edges = 0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    m_wr    = 0;
    m_rd    = 0;
  endtask

  task automatic model_step(input bit r, input bit w, input int a, input int d);
    m_valid = 1'b0;
    if (m_edges < DEPTH) begin
      m_edges++;
      if (r || w) m_perr = 1'b1;
    end else if (r && w) begin
      m_perr = 1'b1;
    end else if (w) begin
      m_mem[a] = d[DW-1:0];
      if (m_wr < CMAX) m_wr++;
    end else if (r) begin
      m_dout  = m_mem[a];
      m_valid = 1'b1;
      if (m_rd < CMAX) m_rd++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'(m_edges < DEPTH));
    chk({tag, ".rd_valid"},  32'(rd_valid),  32'(m_valid));
    chk({tag, ".data_out"},  32'(data_out),  32'(m_dout));
    chk({tag, ".proto_err"}, 32'(proto_err), 32'(m_perr));
    chk({tag, ".wr_count"},  32'(wr_count),  32'(m_wr));
    chk({tag, ".rd_count"},  32'(rd_count),  32'(m_rd));
  endtask

  task automatic cycle(input bit r, input bit w, input int a, input int d, input string tag);
    read    = r;
    write   = w;
    addr    = a[AW-1:0];
    data_in = d[DW-1:0];
    @(posedge clk);
    model_step(r, w, a, d);
    #1;
    check_all(tag);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_reset();
    read  = 1'b0;
    write = 1'b0;
    rst   = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, tag);
  endtask

  function automatic int letter();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(8'h41, 8'h5A));
    return int'($urandom_range(8'h61, 8'h7A));
  endfunction

  initial begin
    //                 r  w  a   d      dout   v  p  wr rd
    tbl[0] = '{1'b0, 1'b1, 5'd5, 8'h41, 8'h00, 1'b0, 1'b0, 1, 0};
    tbl[1] = '{1'b1, 1'b0, 5'd5, 8'h00, 8'h41, 1'b1, 1'b0, 1, 1};
    tbl[2] = '{1'b1, 1'b0, 5'd5, 8'h00, 8'h41, 1'b1, 1'b0, 1, 2};
    tbl[3] = '{1'b0, 1'b0, 5'd0, 8'h00, 8'h41, 1'b0, 1'b0, 1, 2};
    tbl[4] = '{1'b0, 1'b1, 5'd3, 8'h22, 8'h41, 1'b0, 1'b0, 2, 2};
    tbl[5] = '{1'b1, 1'b1, 5'd3, 8'hFF, 8'h41, 1'b0, 1'b1, 2, 2};
    tbl[6] = '{1'b1, 1'b0, 5'd3, 8'h00, 8'h22, 1'b1, 1'b1, 2, 3};
    tbl[7] = '{1'b1, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 1'b1, 2, 4};

    // clear sequence length and zeroed contents
    do_reset();
    idle(DEPTH, "clear");
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, a, 0, "zero_rd");
    chk("zero_rd.count", 32'(rd_count), 32'd32);

    // constant vector table
    do_reset();
    idle(DEPTH, "tbl_clear");
    for (int i = 0; i < 8; i++) begin
      read    = tbl[i].r;
      write   = tbl[i].w;
      addr    = tbl[i].a;
      data_in = tbl[i].d;
      @(posedge clk);
      model_step(tbl[i].r, tbl[i].w, int'(tbl[i].a), int'(tbl[i].d));
      #1;
      chk($sformatf("tbl%0d.busy", i),      32'(busy),      32'd0);
      chk($sformatf("tbl%0d.data_out", i),  32'(data_out),  32'(tbl[i].e_dout));
      chk($sformatf("tbl%0d.rd_valid", i),  32'(rd_valid),  32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.proto_err", i), 32'(proto_err), 32'(tbl[i].e_perr));
      chk($sformatf("tbl%0d.wr_count", i),  32'(wr_count),  32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d.rd_count", i),  32'(rd_count),  32'(tbl[i].e_rd));
      read  = 1'b0;
      write = 1'b0;
    end

    // random letters everywhere, read back
    do_reset();
    idle(DEPTH, "let_clear");
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, a, letter(), "let_wr");
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, a, 0, "let_rd");
    chk("letters.proto_err", 32'(proto_err), 32'd0);

    // write during cycle 10 of CLEAR is rejected
    do_reset();
    idle(9, "busy_idle");
    cycle(1'b0, 1'b1, 7, 8'h55, "busy_wr");
    idle(DEPTH - 10, "busy_rest");
    cycle(1'b1, 1'b0, 7, 0, "busy_rd");
    chk("busy_wr.data", 32'(data_out), 32'h00);

    // reset in the middle of CLEAR after the array was filled
    do_reset();
    idle(DEPTH, "aa_clear");
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, a, 8'hAA, "aa_wr");
    do_reset();
    idle(14, "mid_clear");
    do_reset();
    idle(DEPTH, "re_clear");
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, a, 0, "aa_rd");

    // randomized traffic
    do_reset();
    idle(DEPTH, "rnd_clear");
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      cycle(sel < 4 || sel == 9, sel >= 4, int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, 255)), "rnd");
    end

    // counter saturation
    do_reset();
    idle(DEPTH, "sat_clear");
    for (int i = 0; i < CMAX + 6; i++)
      cycle(1'b1, 1'b0, int'($urandom_range(0, DEPTH - 1)), 0, "sat_rd");
    for (int i = 0; i < CMAX + 6; i++)
      cycle(1'b0, 1'b1, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)), "sat_wr");
    chk("sat.rd_count", 32'(rd_count), 32'(CMAX));
    chk("sat.wr_count", 32'(wr_count), 32'(CMAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
